dp_block_ram_fill: RTL and testbench

Single-clock, true dual-port block RAM. Successor to the team's fixed dual-port RAM, with these additions:
- Per-lane write enables.
- Selectable read latency and read-during-write mode.
- Read-valid strobes and a write-collision flag.
- A built-in fill sequencer that clears or paints the whole array.
Used as the frame/tile store between the Painter engine (port A) and the display scanner (port B).

---
 rtl/dp_block_ram_fill_pkg.sv | 20 ++
 rtl/ram_fill_seq.sv | 79 +++++++
 rtl/dp_block_ram_fill.sv | 173 +++++++++++++++++
 tb/tb_dp_block_ram_fill.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_block_ram_fill_pkg.sv
// Shared constants, fill-sequencer state encoding and lane helpers for dp_block_ram_fill.
package dp_block_ram_fill_pkg;

  // Same-port read-during-write behaviour
  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Fill sequencer states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

  // Width of one write-enable lane
  function automatic int unsigned lane_width(input int unsigned data, input int unsigned lanes);
    return data / lanes;
  endfunction

endpackage

// File: rtl/ram_fill_seq.sv
// Fill sequencer: on an accepted start it writes the latched fill word to every address,
// one word per cycle, then pulses done. Its write port overrides port A of the RAM.
module ram_fill_seq #(
  parameter int unsigned DATA = 18,
  parameter int unsigned ADDR = 14,
  parameter int unsigned SIZE = 12288
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fill_start,
  input  logic [DATA-1:0] fill_data,
  output logic            fill_busy,
  output logic            fill_done,
  output logic            fill_we,
  output logic [ADDR-1:0] fill_addr,
  output logic [DATA-1:0] fill_wdata
);
  import dp_block_ram_fill_pkg::*;

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(SIZE - 1);

  fill_state_e     state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic [DATA-1:0] data_q, data_d;

  // State, counter and fill-word registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next state: start is only honoured in idle; the last write moves straight to done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d = StFill;
          cnt_d   = '0;
          data_d  = fill_data;
        end
      end
      StFill: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + ADDR'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    fill_busy = 1'b0;
    fill_done = 1'b0;
    unique case (state_q)
      StFill:  fill_busy = 1'b1;
      StDone:  fill_done = 1'b1;
      default: ;
    endcase
  end

  assign fill_we    = fill_busy;
  assign fill_addr  = cnt_q;
  assign fill_wdata = data_q;

endmodule

// File: rtl/dp_block_ram_fill.sv
// True dual-port RAM with lane write enables, selectable read latency and
// read-during-write mode, read-valid strobes, write-collision flag and a fill sequencer.
// RD_LAT must be 1 or 2; DATA must be a multiple of LANES; SIZE <= 2**ADDR.
module dp_block_ram_fill #(
  parameter int unsigned DATA     = 18,
  parameter int unsigned ADDR     = 14,
  parameter int unsigned SIZE     = 12288,
  parameter int unsigned LANES    = 2,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [LANES-1:0] wea,
  input  logic [ADDR-1:0]  addra,
  input  logic [DATA-1:0]  dina,
  output logic [DATA-1:0]  douta,
  output logic             vala,
  input  logic             enb,
  input  logic [LANES-1:0] web,
  input  logic [ADDR-1:0]  addrb,
  input  logic [DATA-1:0]  dinb,
  output logic [DATA-1:0]  doutb,
  output logic             valb,
  input  logic             fill_start,
  input  logic [DATA-1:0]  fill_data,
  output logic             fill_busy,
  output logic             fill_done,
  output logic             collision
);
  import dp_block_ram_fill_pkg::*;

  localparam int unsigned W           = lane_width(DATA, LANES);
  localparam int unsigned IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR:0] SIZE_V    = SIZE[ADDR:0];
  localparam bit          WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  // Expand lane enables into a per-bit mask
  function automatic logic [DATA-1:0] lane_mask(input logic [LANES-1:0] we);
    logic [DATA-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*W +: W] = {W{we[i]}};
    end
    return m;
  endfunction

  logic [DATA-1:0] mem [SIZE];

  logic             fill_we;
  logic [ADDR-1:0]  fill_addr;
  logic [DATA-1:0]  fill_wdata;
  logic [IDX_W-1:0] fill_idx;

  logic             in_range_a, in_range_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             wr_a, wr_b;
  logic [DATA-1:0]  old_a, old_b;
  logic [DATA-1:0]  mask_a, mask_b;
  logic [DATA-1:0]  rd_word_a, rd_word_b;

  logic             pipe_va, pipe_vb;
  logic [DATA-1:0]  pipe_a, pipe_b;

  ram_fill_seq #(
    .DATA (DATA),
    .ADDR (ADDR),
    .SIZE (SIZE)
  ) u_fill_seq (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_data  (fill_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_wdata (fill_wdata)
  );

  assign fill_idx   = fill_addr[IDX_W-1:0];
  assign in_range_a = ({1'b0, addra} < SIZE_V);
  assign in_range_b = ({1'b0, addrb} < SIZE_V);
  assign idx_a      = addra[IDX_W-1:0];
  assign idx_b      = addrb[IDX_W-1:0];

  // User writes are dropped while the sequencer owns the array
  assign wr_a = ena && (|wea) && in_range_a && !fill_busy;
  assign wr_b = enb && (|web) && in_range_b && !fill_busy;

  assign mask_a = lane_mask(wea);
  assign mask_b = lane_mask(web);

  // Out-of-range reads return zero
  assign old_a = in_range_a ? mem[idx_a] : '0;
  assign old_b = in_range_b ? mem[idx_b] : '0;

  // Write-first returns this port's own write merged over the old word; the other
  // port always sees old data
  always_comb begin
    rd_word_a = old_a;
    rd_word_b = old_b;
    if (WRITE_FIRST && wr_a) rd_word_a = (old_a & ~mask_a) | (dina & mask_a);
    if (WRITE_FIRST && wr_b) rd_word_b = (old_b & ~mask_b) | (dinb & mask_b);
  end

  // Array write: B lanes are issued before A so A wins any lane both ports enable
  always_ff @(posedge clk) begin
    if (fill_we) mem[fill_idx] <= fill_wdata;
    for (int i = 0; i < LANES; i++) begin
      if (wr_b && web[i]) mem[idx_b][i*W +: W] <= dinb[i*W +: W];
      if (wr_a && wea[i]) mem[idx_a][i*W +: W] <= dina[i*W +: W];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic            s1_va_q, s1_vb_q;
      logic [DATA-1:0] s1_a_q, s1_b_q;

      // Extra read stage for two-cycle latency
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_va_q <= 1'b0;
          s1_vb_q <= 1'b0;
          s1_a_q  <= '0;
          s1_b_q  <= '0;
        end else begin
          s1_va_q <= ena;
          s1_vb_q <= enb;
          if (ena) s1_a_q <= rd_word_a;
          if (enb) s1_b_q <= rd_word_b;
        end
      end

      assign pipe_va = s1_va_q;
      assign pipe_vb = s1_vb_q;
      assign pipe_a  = s1_a_q;
      assign pipe_b  = s1_b_q;
    end else begin : g_lat1
      assign pipe_va = ena;
      assign pipe_vb = enb;
      assign pipe_a  = rd_word_a;
      assign pipe_b  = rd_word_b;
    end
  endgenerate

  // Output stage: data holds until the next completing read; valids are single pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta <= '0;
      doutb <= '0;
      vala  <= 1'b0;
      valb  <= 1'b0;
    end else begin
      vala <= pipe_va;
      valb <= pipe_vb;
      if (pipe_va) douta <= pipe_a;
      if (pipe_vb) doutb <= pipe_b;
    end
  end

  // Collision flag, one cycle after both ports wrote the same in-range word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision <= 1'b0;
    end else begin
      collision <= wr_a && wr_b && (addra == addrb);
    end
  end

endmodule

// File: tb/tb_dp_block_ram_fill.sv
// Bench for dp_block_ram_fill: two instances (latency 1 read-first, latency 2 write-first)
// share stimulus and are compared every cycle against a word-level model of the RAM.
module tb_dp_block_ram_fill;

  localparam int unsigned DATA  = 18;
  localparam int unsigned ADDR  = 5;
  localparam int unsigned SIZE  = 16;
  localparam int unsigned LANES = 2;

  logic clk = 1'b0;
  logic rst;

  logic        ena, enb, fill_start;
  logic [1:0]  wea, web;
  logic [4:0]  addra, addrb;
  logic [17:0] dina, dinb, fill_data;

  logic [17:0] douta1, doutb1, douta2, doutb2;
  logic        vala1, valb1, busy1, done1, coll1;
  logic        vala2, valb2, busy2, done2, coll2;

  always #5 clk = ~clk;

  dp_block_ram_fill #(
    .DATA(DATA), .ADDR(ADDR), .SIZE(SIZE), .LANES(LANES), .RD_LAT(1), .RDW_MODE(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .vala(vala1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .valb(valb1),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(busy1), .fill_done(done1), .collision(coll1)
  );

  dp_block_ram_fill #(
    .DATA(DATA), .ADDR(ADDR), .SIZE(SIZE), .LANES(LANES), .RD_LAT(2), .RDW_MODE(1)
  ) dut2 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta2), .vala(vala2),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb2), .valb(valb2),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(busy2), .fill_done(done2), .collision(coll2)
  );

  // Reference model state
  logic [17:0] mm [16];
  logic [17:0] e1_da, e1_db, e2_da, e2_db, p2_da, p2_db, f_word;
  logic        e1_va, e1_vb, e2_va, e2_vb, p2_va, p2_vb;
  logic        m_busy, m_done, m_coll;
  int          f_idx;
  int          n_total, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mask(input logic [1:0] we);
    return {{9{we[1]}}, {9{we[0]}}};
  endfunction

  function automatic logic [17:0] rd_old(input logic [4:0] a);
    if (a < 5'd16) return mm[a[3:0]];
    return '0;
  endfunction

  task automatic model_reset();
    e1_da = '0; e1_db = '0; e2_da = '0; e2_db = '0; p2_da = '0; p2_db = '0;
    e1_va = 0; e1_vb = 0; e2_va = 0; e2_vb = 0; p2_va = 0; p2_vb = 0;
    m_busy = 0; m_done = 0; m_coll = 0; f_idx = 0; f_word = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    logic        wa, wb;
    logic [17:0] ra_old, rb_old, ra_new, rb_new;
    if (rst) return;
    wa = ena && (wea != 2'b00) && !m_busy && (addra < 5'd16);
    wb = enb && (web != 2'b00) && !m_busy && (addrb < 5'd16);
    ra_old = rd_old(addra);
    rb_old = rd_old(addrb);
    ra_new = wa ? ((ra_old & ~mask(wea)) | (dina & mask(wea))) : ra_old;
    rb_new = wb ? ((rb_old & ~mask(web)) | (dinb & mask(web))) : rb_old;
    // Instance 1: result visible right after this edge, old data
    e1_va = ena;
    e1_vb = enb;
    if (ena) e1_da = ra_old;
    if (enb) e1_db = rb_old;
    // Instance 2: result visible one edge later, own write merged in
    e2_va = p2_va;
    e2_vb = p2_vb;
    if (p2_va) e2_da = p2_da;
    if (p2_vb) e2_db = p2_db;
    p2_va = ena;
    p2_vb = enb;
    p2_da = ra_new;
    p2_db = rb_new;
    m_coll = wa && wb && (addra == addrb);
    if (wb) mm[addrb[3:0]] = (mm[addrb[3:0]] & ~mask(web)) | (dinb & mask(web));
    if (wa) mm[addra[3:0]] = (mm[addra[3:0]] & ~mask(wea)) | (dina & mask(wea));
    if (m_busy) begin
      mm[f_idx] = f_word;
      if (f_idx == 15) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        f_idx++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (fill_start) begin
      m_busy = 1;
      f_idx  = 0;
      f_word = fill_data;
    end
  endtask

  task automatic compare_all();
    check("busy1", 32'(busy1), 32'(m_busy));
    check("busy2", 32'(busy2), 32'(m_busy));
    check("done1", 32'(done1), 32'(m_done));
    check("done2", 32'(done2), 32'(m_done));
    check("coll1", 32'(coll1), 32'(m_coll));
    check("coll2", 32'(coll2), 32'(m_coll));
    check("vala1", 32'(vala1), 32'(e1_va));
    check("valb1", 32'(valb1), 32'(e1_vb));
    check("vala2", 32'(vala2), 32'(e2_va));
    check("valb2", 32'(valb2), 32'(e2_vb));
    check("douta1", 32'(douta1), 32'(e1_da));
    check("doutb1", 32'(doutb1), 32'(e1_db));
    check("douta2", 32'(douta2), 32'(e2_da));
    check("doutb2", 32'(doutb2), 32'(e2_db));
  endtask

  task automatic idle();
    ena = 0; wea = '0; addra = '0; dina = '0;
    enb = 0; web = '0; addrb = '0; dinb = '0;
    fill_start = 0; fill_data = '0;
  endtask

  // One clock: model the edge, then sample on the falling edge
  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [1:0] we, input logic [17:0] d);
    idle(); ena = 1; wea = we; addra = a; dina = d;
    cyc();
  endtask

  task automatic rd_a(input logic [4:0] a);
    idle(); ena = 1; addra = a;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc;
    n_total = 0;
    n_bad   = 0;
    idle();
    rst = 1;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 0;

    // Give every word a known value
    for (int i = 0; i < 16; i++) wr_a(5'(i), 2'b11, 18'(i * 32'h1111));

    // Full write then read, both latencies
    wr_a(5'd5, 2'b11, 18'h2AAAA);
    rd_a(5'd5);
    check("t1_l1_val", 32'(vala1), 32'd1);
    check("t1_l1_data", 32'(douta1), 32'h2AAAA);
    idle(); cyc();
    check("t1_l2_val", 32'(vala2), 32'd1);
    check("t1_l2_data", 32'(douta2), 32'h2AAAA);
    check("t1_l1_nval", 32'(vala1), 32'd0);

    // Lane 0 only
    wr_a(5'd7, 2'b11, 18'h3FFFF);
    wr_a(5'd7, 2'b01, 18'h00000);
    rd_a(5'd7);
    check("t2_l1_data", 32'(douta1), 32'h3FE00);
    idle(); cyc();
    check("t2_l2_data", 32'(douta2), 32'h3FE00);

    // Read-during-write on A, cross-port read on B
    wr_a(5'd9, 2'b11, 18'h11111);
    idle(); ena = 1; wea = 2'b11; addra = 5'd9; dina = 18'h22222; enb = 1; addrb = 5'd9;
    cyc();
    check("t3_rf_a", 32'(douta1), 32'h11111);
    check("t3_rf_b", 32'(doutb1), 32'h11111);
    idle(); cyc();
    check("t3_wf_a", 32'(douta2), 32'h22222);
    check("t3_wf_b", 32'(doutb2), 32'h11111);

    // Same-address write collision
    idle(); ena = 1; wea = 2'b11; addra = 5'd3; dina = 18'h00001;
    enb = 1; web = 2'b11; addrb = 5'd3; dinb = 18'h3FFFF;
    cyc();
    check("t4_coll1", 32'(coll1), 32'd1);
    check("t4_coll2", 32'(coll2), 32'd1);
    rd_a(5'd3);
    check("t4_rd", 32'(douta1), 32'h00001);
    check("t4_coll_drop", 32'(coll1), 32'd0);

    // Out-of-range write ignored, read returns zero with valid
    wr_a(5'd20, 2'b11, 18'h15555);
    rd_a(5'd20);
    check("oor_val", 32'(vala1), 32'd1);
    check("oor_data", 32'(douta1), 32'd0);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      idle();
      ena   = 1'($urandom_range(0, 1));
      wea   = 2'($urandom_range(0, 3));
      addra = 5'($urandom_range(0, 19));
      dina  = 18'($urandom);
      enb   = 1'($urandom_range(0, 1));
      web   = 2'($urandom_range(0, 3));
      addrb = 5'($urandom_range(0, 19));
      dinb  = 18'($urandom);
      if ($urandom_range(0, 3) == 0) addrb = addra;
      fill_start = ($urandom_range(0, 99) == 0);
      fill_data  = 18'($urandom);
      cyc();
    end
    idle();
    for (int k = 0; k < 40 && (m_busy || m_done); k++) cyc();

    // Full fill with a dropped write and an ignored second start
    idle(); fill_start = 1; fill_data = 18'h12345;
    cyc();
    bc = 0;
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy1) bc++;
      if (done1) dc++;
      idle();
      ena = 1; addra = 5'(k);
      enb = 1; addrb = 5'(k);
      if (k == 4) begin wea = 2'b11; addra = 5'd4; dina = 18'h3FFFF; end
      if (k == 6) begin fill_start = 1; fill_data = 18'h00777; end
      cyc();
    end
    check("fill_busy_len", 32'(bc), 32'd16);
    check("fill_done_cnt", 32'(dc), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_a(5'(i));
      check("fill_rd", 32'(douta1), 32'h12345);
    end

    // Reset part way through a fill
    for (int i = 0; i < 16; i++) wr_a(5'(i), 2'b11, 18'h100 + 18'(i));
    idle(); fill_start = 1; fill_data = 18'h12345;
    cyc();
    idle();
    repeat (8) cyc();
    check("pre_rst_busy", 32'(busy1), 32'd1);
    rst = 1;
    #1;
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    model_reset();
    cyc();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      rd_a(5'(i));
      check("rst_fill_rd", 32'(douta1), (i < 8) ? 32'h12345 : 32'h100 + 32'(i));
    end
    idle();
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
